// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset core: datapath, control FSM and one shared instruction/data memory port.
// Each instruction takes 2-5 states, and memory may stall any access indefinitely.
module mc_datapath #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter bit                BNE_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_done,
    output logic              trap,
    input  logic [4:0]        dbg_raddr,
    output logic [31:0]       dbg_rdata
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    state_t      state;
    state_t      state_next;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [31:0] regs [32];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] pc32;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] alu_result;
    logic        op_legal;
    logic        is_branch;
    logic        branch_taken;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    // PC is zero-extended to 32 bits so jump/branch arithmetic is width independent.
    always_comb begin
        pc32 = '0;
        pc32[ADDR_W-1:0] = pc;
    end

    assign jump_target   = {pc32[31:28], ir[25:0], 2'b00};
    assign branch_target = pc32 + {imm_sext[29:0], 2'b00};
    assign is_branch     = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign branch_taken  = (opcode == OP_BEQ) ? (a == b) : (a != b);

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_R:    op_legal = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                                (funct == F_OR)  || (funct == F_SLT);
            OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: op_legal = 1'b1;
            OP_BNE:  op_legal = BNE_EN;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (funct)
            F_ADD:   alu_result = a + b;
            F_SUB:   alu_result = a - b;
            F_AND:   alu_result = a & b;
            F_OR:    alu_result = a | b;
            F_SLT:   alu_result = {31'd0, $signed(a) < $signed(b)};
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (!op_legal)            state_next = S_TRAP;
                else if (opcode == OP_J)  state_next = S_FETCH;
                else                      state_next = S_EXEC;
            end
            S_EXEC: begin
                if (is_branch)                              state_next = S_FETCH;
                else if (opcode == OP_LW || opcode == OP_SW) state_next = S_MEM;
                else                                         state_next = S_WB;
            end
            S_MEM:    if (mem_ready) state_next = (opcode == OP_LW) ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    // Memory handshake: mem_req is valid, mem_ready is ready; the transfer happens on the
    // rising edge where both are high, and mem_addr/mem_we/mem_wdata hold until then.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc;
        mem_wdata  = b;
        instr_done = 1'b0;
        reg_we     = 1'b0;
        reg_waddr  = rt;
        reg_wdata  = alu_out;
        case (state)
            S_FETCH:  mem_req = 1'b1;
            S_DECODE: instr_done = op_legal && (opcode == OP_J);
            S_EXEC:   instr_done = is_branch;
            S_MEM: begin
                mem_req    = 1'b1;
                mem_we     = (opcode == OP_SW);
                mem_addr   = alu_out[ADDR_W-1:0];
                instr_done = (opcode == OP_SW) && mem_ready;
            end
            S_WB: begin
                instr_done = 1'b1;
                reg_we     = 1'b1;
                if (opcode == OP_R)       reg_waddr = rd;
                if (opcode == OP_LW)      reg_wdata = mdr;
            end
            default: ;
        endcase
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            instr_done = 1'b0;
            reg_we     = 1'b0;
        end
    end

    assign trap = (state == S_TRAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_W'(4);
                    end
                end
                S_DECODE: begin
                    a       <= regs[rs];
                    b       <= regs[rt];
                    alu_out <= branch_target;
                    if (op_legal && opcode == OP_J) pc <= jump_target[ADDR_W-1:0];
                end
                S_EXEC: begin
                    if (is_branch) begin
                        if (branch_taken) pc <= alu_out[ADDR_W-1:0];
                    end else if (opcode == OP_R) begin
                        alu_out <= alu_result;
                    end else begin
                        alu_out <= a + imm_sext;
                    end
                end
                S_MEM: begin
                    if (mem_ready && opcode == OP_LW) mdr <= mem_rdata;
                end
                default: ;
            endcase
            if (reg_we && reg_waddr != 5'd0) regs[reg_waddr] <= reg_wdata;
        end
    end

    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : regs[dbg_raddr];

endmodule
